spart_bus_if: RTL and testbench

//  Responder for the SPART processor I/O bus: decodes iocs/iorw/ioaddr cycles issued by the driver.

---
 rtl/spart_pkg.sv | 39 +++
 rtl/spart_bus_if_if.sv | 21 ++
 rtl/spart_baud_gen.sv | 46 ++++
 rtl/spart_bus_if.sv | 145 ++++++++++++++
 tb/tb_spart_bus_if.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spart_pkg
// Description : Shared constants for the SPART bus responder: I/O address
//               map, status register bit positions and receive-fill states.
// Revision    : 1.0  initial release
// ============================================================================
package spart_pkg;

  localparam logic [1:0] ADDR_BUF  = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DBL  = 2'b10;
  localparam logic [1:0] ADDR_DBH  = 2'b11;

  localparam int STAT_RDA   = 0;
  localparam int STAT_TBR   = 1;
  localparam int STAT_OVR   = 2;
  localparam int STAT_TXERR = 3;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_ACK  = 2'd1,
    RX_WAIT = 2'd2
  } rx_state_e;

  // Assemble the status byte seen by the driver at ADDR_STAT.
  function automatic logic [7:0] status_byte(input logic txerr, input logic ovr,
                                             input logic tbr, input logic rda);
    logic [7:0] s;
    s              = 8'h00;
    s[STAT_TXERR]  = txerr;
    s[STAT_OVR]    = ovr;
    s[STAT_TBR]    = tbr;
    s[STAT_RDA]    = rda;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spart_bus_if_if.sv
`default_nettype none
// ============================================================================
// Module      : spart_bus_if_if
// Description : Processor-side control signals of the SPART I/O bus. The
//               bidirectional data lines stay a plain port on the responder so
//               the tristate is resolved at a module boundary.
// Revision    : 1.0  initial release
// ============================================================================
interface spart_bus_if_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda_out;
  logic       tbr_out;

  modport master (output iocs, output iorw, output ioaddr,
                  input  rda_out, input tbr_out);
  modport slave  (input  iocs, input  iorw, input  ioaddr,
                  output rda_out, output tbr_out);
endinterface
`default_nettype wire

// File: rtl/spart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module      : spart_baud_gen
// Description : 16x baud-enable generator. Down-counter reloads from the
//               divisor when it reaches zero, producing one enable pulse per
//               (divisor + 1) clocks; divisors 0 and 1 give a constant enable.
// Revision    : 1.0  initial release
// ============================================================================
module spart_baud_gen #(
  parameter int               DIV_W   = 16,
  parameter logic [DIV_W-1:0] DIV_RST = 16'd325
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic [DIV_W-1:0] div_i,
  input  wire logic             load_i,
  input  wire logic [DIV_W-1:0] load_val_i,
  output logic                  baud_en_o
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  // Enable on terminal count; a divisor of 1 would otherwise toggle, so the
  // counter parks at 1 and keeps the enable asserted.
  always_comb begin
    baud_en_o = (cnt_q == '0) || ((cnt_q == DIV_W'(1)) && (div_i == DIV_W'(1)));
    cnt_d     = cnt_q - DIV_W'(1);
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (baud_en_o) begin
      cnt_d = div_i;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= DIV_RST;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spart_bus_if.sv
`default_nettype none
// ============================================================================
// Module      : spart_bus_if
// Description : SPART I/O bus responder. Decodes driver cycles, holds the baud
//               divisor, buffers received bytes in a small FIFO and bridges to
//               the tx/rx cores.
// Revision    : 1.0  initial release
// ============================================================================
module spart_bus_if
  import spart_pkg::*;
#(
  parameter int               DIV_W     = 16,
  parameter logic [DIV_W-1:0] DIV_RST   = 16'd325,
  parameter int               RXQ_DEPTH = 4
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  spart_bus_if_if.slave    bus,
  inout  wire  [7:0]       databus_io,
  output logic [7:0]       tx_data_o,
  output logic             wrt_tx_o,
  input  wire logic        tbr_i,
  input  wire logic [7:0]  rx_data_i,
  input  wire logic        rda_i,
  output logic             rd_rx_o,
  output logic             baud_en_o
);

  localparam int               AW       = $clog2(RXQ_DEPTH);
  localparam int               CW       = AW + 1;
  localparam logic [CW-1:0]    FULL_CNT = CW'(RXQ_DEPTH);

  logic             wr, rd, pop, push, ovr_set, empty, full;
  logic             stat_rd, tx_wr, txerr_set, db_load;
  logic [7:0]       rdata;
  logic [7:0]       rxq_q [RXQ_DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    cnt_q;
  logic             ovr_q, txerr_q, wrt_tx_q;
  logic [7:0]       tx_data_q;
  logic [DIV_W-1:0] div_q;
  rx_state_e        state_q, state_d;

  assign wr        = bus.iocs & ~bus.iorw;
  assign rd        = bus.iocs &  bus.iorw;
  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == FULL_CNT);
  assign pop       = rd && (bus.ioaddr == ADDR_BUF) && !empty;
  assign stat_rd   = rd && (bus.ioaddr == ADDR_STAT);
  assign tx_wr     = wr && (bus.ioaddr == ADDR_BUF);
  assign txerr_set = tx_wr && !tbr_i;
  assign db_load   = wr && (bus.ioaddr == ADDR_DBH);

  // Receive-fill FSM: take one byte per rda assertion, then wait for the rx
  // core to drop rda before arming again. A pop on the same edge frees a slot.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    ovr_set = 1'b0;
    rd_rx_o = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (rda_i) begin
          state_d = RX_ACK;
          if (!full || pop) push    = 1'b1;
          else              ovr_set = 1'b1;
        end
      end
      RX_ACK: begin
        rd_rx_o = 1'b1;
        state_d = RX_WAIT;
      end
      RX_WAIT: begin
        if (!rda_i) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // FSM state, queue pointers/count, flags, tx and divisor registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RX_IDLE;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      ovr_q     <= 1'b0;
      txerr_q   <= 1'b0;
      wrt_tx_q  <= 1'b0;
      tx_data_q <= 8'h00;
      div_q     <= DIV_RST;
    end else begin
      state_q  <= state_d;
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      cnt_q    <= cnt_q + CW'(push) - CW'(pop);
      // A set on the clearing edge wins so an event is never lost.
      if (ovr_set)      ovr_q   <= 1'b1;
      else if (stat_rd) ovr_q   <= 1'b0;
      if (txerr_set)    txerr_q <= 1'b1;
      else if (stat_rd) txerr_q <= 1'b0;
      wrt_tx_q <= tx_wr && tbr_i;
      if (tx_wr && tbr_i) tx_data_q <= databus_io;
      if (wr && (bus.ioaddr == ADDR_DBL)) div_q[7:0]       <= databus_io;
      if (db_load)                        div_q[DIV_W-1:8] <= (DIV_W-8)'(databus_io);
    end
  end

  // Queue storage; contents are don't-care while the count is zero.
  always_ff @(posedge clk) begin
    if (push) rxq_q[wptr_q] <= rx_data_i;
  end

  // Zero-wait-state read mux from registered state.
  always_comb begin
    rdata = 8'h00;
    case (bus.ioaddr)
      ADDR_BUF:  rdata = empty ? 8'h00 : rxq_q[rptr_q];
      ADDR_STAT: rdata = status_byte(txerr_q, ovr_q, tbr_i, !empty);
      ADDR_DBL:  rdata = div_q[7:0];
      ADDR_DBH:  rdata = 8'(div_q >> 8);
      default:   rdata = 8'h00;
    endcase
  end

  assign databus_io  = rd ? rdata : 8'hzz;
  assign tx_data_o   = tx_data_q;
  assign wrt_tx_o    = wrt_tx_q;
  assign bus.rda_out = !empty;
  assign bus.tbr_out = tbr_i;

  spart_baud_gen #(
    .DIV_W   (DIV_W),
    .DIV_RST (DIV_RST)
  ) u_baud (
    .clk        (clk),
    .rst_n      (rst_n),
    .div_i      (div_q),
    .load_i     (db_load),
    .load_val_i (DIV_W'({databus_io, div_q[7:0]})),
    .baud_en_o  (baud_en_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_spart_bus_if.sv
`default_nettype none
// ============================================================================
// Module      : tb_spart_bus_if
// Description : Scoreboard bench for spart_bus_if. Stimulus tasks update a
//               behavioural model (byte queue, flags, divisor) and queue the
//               expected read data / tx bytes; a negedge monitor checks them.
// Revision    : 1.0  initial release
// ============================================================================
module tb_spart_bus_if;
  import spart_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spart_bus_if_if bus ();
  wire  [7:0] databus;
  logic [7:0] drv_val = 8'h00;
  logic       drv_en  = 1'b0;
  assign databus = drv_en ? drv_val : 8'hzz;

  logic [7:0] tx_data, rx_data = 8'h00;
  logic       wrt_tx, rd_rx, baud_en;
  logic       tbr = 1'b1, rda = 1'b0;

  spart_bus_if dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .databus_io (databus),
    .tx_data_o  (tx_data),
    .wrt_tx_o   (wrt_tx),
    .tbr_i      (tbr),
    .rx_data_i  (rx_data),
    .rda_i      (rda),
    .rd_rx_o    (rd_rx),
    .baud_en_o  (baud_en)
  );

  // Behavioural model of the responder's visible state.
  logic [7:0]  mq [$];
  logic        m_ovr = 1'b0, m_txerr = 1'b0;
  logic [15:0] m_div = 16'd325;

  // Scoreboard queues.
  logic [7:0] exp_rd [$];
  string      rd_name [$];
  logic [7:0] exp_tx [$];

  int vectors = 0, miscompares = 0;

  task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %02h, expected %02h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: event missing or unexpected", nm);
  endtask

  // Monitor: compares DUT outputs against the scoreboard away from posedge.
  logic last_wrt = 1'b0, last_rdrx = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.iocs && bus.iorw) begin
          if (exp_rd.size() == 0) fail("rd_unexpected");
          else check8(rd_name.pop_front(), databus, exp_rd.pop_front());
        end
        if (wrt_tx) begin
          check8("wrt_tx_width", {7'b0, last_wrt}, 8'h00);
          if (exp_tx.size() == 0) fail("wrt_tx_spurious");
          else check8("tx_data", tx_data, exp_tx.pop_front());
        end
        if (rd_rx) check8("rd_rx_width", {7'b0, last_rdrx}, 8'h00);
      end
      last_wrt  = wrt_tx;
      last_rdrx = rd_rx;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic [1:0] a, input string nm);
    logic [7:0] e;
    case (a)
      ADDR_BUF:  e = (mq.size() != 0) ? mq[0] : 8'h00;
      ADDR_STAT: e = {4'b0, m_txerr, m_ovr, tbr, mq.size() != 0};
      ADDR_DBL:  e = m_div[7:0];
      default:   e = m_div[15:8];
    endcase
    bus.iocs = 1'b1; bus.iorw = 1'b1; bus.ioaddr = a;
    exp_rd.push_back(e);
    rd_name.push_back(nm);
    if (a == ADDR_BUF && mq.size() != 0) void'(mq.pop_front());
    if (a == ADDR_STAT) begin m_ovr = 1'b0; m_txerr = 1'b0; end
    tick();
    bus.iocs = 1'b0; bus.iorw = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d, input bit strobe_kept);
    bus.iocs = 1'b1; bus.iorw = 1'b0; bus.ioaddr = a;
    drv_val = d; drv_en = 1'b1;
    case (a)
      ADDR_BUF:  if (tbr) begin if (strobe_kept) exp_tx.push_back(d); end
                 else m_txerr = 1'b1;
      ADDR_DBL:  m_div[7:0]  = d;
      ADDR_DBH:  m_div[15:8] = d;
      default:   ;
    endcase
    tick();
    bus.iocs = 1'b0; drv_en = 1'b0;
  endtask

  // rx core: offers a byte, waits for the ack, then clears rda.
  task automatic wait_rd_rx(input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (rd_rx) seen = 1'b1;
    end
    check8(nm, {7'b0, seen}, 8'h01);
    tick();
    rda = 1'b0;
    tick();
    tick();
  endtask

  task automatic present(input logic [7:0] b);
    rx_data = b; rda = 1'b1;
    if (mq.size() < 4) mq.push_back(b);
    else m_ovr = 1'b1;
    wait_rd_rx("rd_rx_ack");
  endtask

  // Byte offered on the same edge as a head pop.
  task automatic present_with_pop(input logic [7:0] b);
    rx_data = b; rda = 1'b1;
    bus.iocs = 1'b1; bus.iorw = 1'b1; bus.ioaddr = ADDR_BUF;
    exp_rd.push_back(mq[0]);
    rd_name.push_back("pop_push_head");
    void'(mq.pop_front());
    mq.push_back(b);
    tick();
    bus.iocs = 1'b0; bus.iorw = 1'b0;
    wait_rd_rx("rd_rx_pop_push");
  endtask

  task automatic measure_baud(input int exp, input string nm);
    int n = 0;
    bit got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      if (baud_en) got = 1'b1;
    end
    if (!got) fail({nm, "_timeout"});
    else begin
      got = 1'b0;
      for (int i = 0; i < 2000 && !got; i++) begin
        @(negedge clk);
        n++;
        if (baud_en) got = 1'b1;
      end
      vectors++;
      if (!got || n != exp) begin
        miscompares++;
        $display("FAIL %s: period %0d clks, expected %0d", nm, n, exp);
      end
    end
    tick();
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovr = 1'b0; m_txerr = 1'b0; m_div = 16'd325;
  endtask

  initial begin
    bus.iocs = 1'b0; bus.iorw = 1'b0; bus.ioaddr = 2'b00;
    // 1: reset state; tb drives the bus to show the block is not driving it.
    drv_val = 8'h5A; drv_en = 1'b1;
    repeat (3) @(negedge clk);
    check8("rst_databus", databus, 8'h5A);
    check8("rst_baud_en", {7'b0, baud_en}, 8'h00);
    check8("rst_wrt_tx",  {7'b0, wrt_tx},  8'h00);
    check8("rst_rd_rx",   {7'b0, rd_rx},   8'h00);
    check8("rst_rda_out", {7'b0, bus.rda_out}, 8'h00);
    check8("rst_tx_data", tx_data, 8'h00);
    drv_en = 1'b0;
    tick();
    rst_n = 1'b1;
    measure_baud(326, "baud_reset");
    bus_read(ADDR_DBL, "div_lo_rst");
    bus_read(ADDR_DBH, "div_hi_rst");

    // 2: divisor programming and the degenerate divisors.
    bus_write(ADDR_DBL, 8'h0A, 1'b1);
    bus_write(ADDR_DBH, 8'h00, 1'b1);
    measure_baud(11, "baud_div10");
    bus_read(ADDR_DBL, "div_lo_0a");
    bus_write(ADDR_DBL, 8'h01, 1'b1);
    bus_write(ADDR_DBH, 8'h00, 1'b1);
    measure_baud(1, "baud_div1");
    bus_write(ADDR_DBL, 8'h00, 1'b1);
    bus_write(ADDR_DBH, 8'h00, 1'b1);
    measure_baud(1, "baud_div0");
    bus_write(ADDR_DBL, 8'h0A, 1'b1);
    bus_write(ADDR_DBH, 8'h00, 1'b1);

    // 3: transmit path and tx error flag.
    tbr = 1'b1;
    bus_write(ADDR_BUF, 8'h61, 1'b1);
    tick();
    tbr = 1'b0;
    bus_write(ADDR_BUF, 8'h62, 1'b1);
    tick();
    bus_read(ADDR_STAT, "stat_txerr");
    bus_read(ADDR_STAT, "stat_cleared");
    tbr = 1'b1;

    // 4: two received bytes.
    present(8'h41);
    present(8'h42);
    bus_read(ADDR_STAT, "stat_rda");
    bus_read(ADDR_BUF,  "rx_first");
    bus_read(ADDR_BUF,  "rx_second");
    bus_read(ADDR_STAT, "stat_empty");
    bus_read(ADDR_BUF,  "rx_empty_read");

    // 5: overrun with a full queue.
    for (int i = 0; i < 5; i++) present(8'h80 + 8'(i));
    bus_read(ADDR_STAT, "stat_ovr");
    for (int i = 0; i < 4; i++) bus_read(ADDR_BUF, "rx_ovr_order");
    bus_read(ADDR_STAT, "stat_after_ovr");

    // 6: push and pop on the same edge while full.
    for (int i = 0; i < 4; i++) present(8'hC0 + 8'(i));
    present_with_pop(8'hC4);
    bus_read(ADDR_STAT, "stat_no_ovr");
    for (int i = 0; i < 4; i++) bus_read(ADDR_BUF, "rx_pop_push_order");
    bus_read(ADDR_STAT, "stat_drained");

    // Randomized mix against the model.
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 4))
        0: begin tbr = 1'($urandom_range(0, 1)); bus_write(ADDR_BUF, 8'($urandom), 1'b1); tick(); end
        1: present(8'($urandom));
        2: bus_read(ADDR_BUF, "rand_buf");
        3: bus_read(ADDR_STAT, "rand_stat");
        default: begin bus_write(ADDR_DBL, 8'($urandom_range(2, 255)), 1'b1); bus_read(ADDR_DBL, "rand_dbl"); end
      endcase
    end
    tbr = 1'b1;

    // 7: reset during the tx strobe cycle with a byte queued.
    present(8'h5C);
    bus_write(ADDR_BUF, 8'h77, 1'b0);
    check8("wrt_tx_pre_rst", {7'b0, wrt_tx}, 8'h01);
    rst_n = 1'b0;
    #1;
    check8("wrt_tx_rst", {7'b0, wrt_tx}, 8'h00);
    check8("rda_out_rst", {7'b0, bus.rda_out}, 8'h00);
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();
    bus_read(ADDR_DBL,  "div_lo_after_rst");
    bus_read(ADDR_STAT, "stat_after_rst");
    bus_read(ADDR_BUF,  "buf_after_rst");
    tick();
    tick();

    check8("rd_sb_leftover", 8'(exp_rd.size()), 8'h00);
    check8("tx_sb_leftover", 8'(exp_tx.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
